// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD counter/decoder datapath.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int         DEC_W         = 10;

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return (nibble <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_onehot.sv
// Combinational BCD digit to one-hot decimal decoder; codes 10..15 decode to
// all-zero and raise invalid.
module bcd_digit_onehot
  import bcd_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [DEC_W-1:0] onehot,
  output logic             invalid
);

  always_comb begin
    onehot  = '0;
    invalid = !bcd_valid(digit);
    if (!invalid) begin
      onehot = DEC_W'(1) << digit;
    end
  end

endmodule

// File: rtl/bcd_count_decoder.sv
// N-digit BCD up/down counter with programmable terminal count, checked load,
// wrap/load-error pulses and per-digit one-hot decode of the registered count.
module bcd_count_decoder
  import bcd_pkg::*;
#(
  parameter int                  DIGITS   = 2,
  parameter logic [4*DIGITS-1:0] TERM_BCD = 8'h99
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*DIGITS-1:0]     load_bcd,
  output logic [4*DIGITS-1:0]     count_bcd,
  output logic [DEC_W*DIGITS-1:0] dec_onehot,
  output logic                    wrap,
  output logic                    load_err
);

  logic [4*DIGITS-1:0]     count_q, count_d;
  logic                    wrap_q, wrap_d;
  logic                    load_err_q, load_err_d;

  logic [4*DIGITS-1:0]     inc_val, dec_val;
  logic                    inc_carry, dec_borrow;
  logic [DIGITS-1:0]       load_nib_invalid;
  logic                    load_ok;

  logic [DIGITS-1:0]       unused_count_invalid;
  logic [DEC_W*DIGITS-1:0] unused_load_onehot;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_onehot u_count_dec (
      .digit   (count_q[4*g +: 4]),
      .onehot  (dec_onehot[DEC_W*g +: DEC_W]),
      .invalid (unused_count_invalid[g])
    );

    bcd_digit_onehot u_load_chk (
      .digit   (load_bcd[4*g +: 4]),
      .onehot  (unused_load_onehot[DEC_W*g +: DEC_W]),
      .invalid (load_nib_invalid[g])
    );
  end

  // With every nibble valid, a raw unsigned compare orders BCD values correctly.
  assign load_ok = (load_nib_invalid == '0) && (load_bcd <= TERM_BCD);

  // Nibble-wise ripple chains: carry/borrow only propagates through 9s/0s.
  always_comb begin
    inc_val    = count_q;
    dec_val    = count_q;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] == BCD_MAX_DIGIT) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = BCD_MAX_DIGIT;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d = load_bcd;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (count_q == TERM_BCD) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (count_q == '0) begin
          count_d = TERM_BCD;
          wrap_d  = 1'b1;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;

endmodule
